mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one physical memory port between the instruction-fetch side (I) and the data side (D) of the
//  rv32i pipeline. D is driven by the mem_read/mem_write/mem_byte_enable fields of rv32i_control_word.
//  Sits between the I/D caches (or fetch/MEM stages) and the shared memory. Serialises transactions and
//  keeps saturating grant/conflict counters for op_getperf readout.
// PARAMETERS
//  DATA_W  256  data width of every port, in bits
//  ADDR_W  32   address width, in bits
//  PERF_W  32   width of each performance counter
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  i_read       in   1       I read request, held until i_resp
//  i_address    in   ADDR_W  I address
//  i_rdata      out  DATA_W  I read data, valid with i_resp
//  i_resp       out  1       I transaction complete (1-cycle pulse)
//  d_read       in   1       D read request, held until d_resp
//  d_write      in   1       D write request, held until d_resp
//  d_address    in   ADDR_W  D address
//  d_wdata      in   DATA_W  D write data
//  d_byte_en    in   DATA_W/8  D write byte mask
//  d_rdata      out  DATA_W  D read data, valid with d_resp
//  d_resp       out  1       D transaction complete (1-cycle pulse)
//  mem_read     out  1       memory read strobe
//  mem_write    out  1       memory write strobe
//  mem_address  out  ADDR_W  memory address, latched at grant
//  mem_wdata    out  DATA_W  memory write data, latched at grant
//  mem_byte_en  out  DATA_W/8  memory byte mask, latched at grant
//  mem_rdata    in   DATA_W  memory read data
//  mem_resp     in   1       memory done, 1-cycle pulse
//  perf_clear   in   1       synchronous clear of all counters
//  perf_i_grant out  PERF_W  number of I grants
//  perf_d_grant out  PERF_W  number of D grants
//  perf_conflict out PERF_W  cycles a request waits while the other port is being served
// BEHAVIOUR
//  Reset: async on rst_n low.
//   - State = IDLE; last_grant = I, so D wins the first tie.
//   - mem_read, mem_write, i_resp, d_resp = 0; latched address/wdata/byte_en = 0; counters = 0.
//  FSM states: IDLE, SERVE_I, SERVE_D.
//  IDLE:
//   - Request from only one port -> go to that SERVE state.
//   - Requests from both ports -> grant the port opposite last_grant (round-robin on contention).
//   - On the grant edge: latch address (plus wdata/byte_en and the op for D); update last_grant;
//     increment that port's grant counter.
//  SERVE_x:
//   - Drive mem_read/mem_write from the latched op; hold the address stable.
//   - Stay in SERVE_x until mem_resp, then go to IDLE.
//  Outputs are decoded from state only; there is no combinational path from requests to mem_* outputs.
//  Response:
//   - x_resp = mem_resp & (state==SERVE_x), combinational.
//   - x_rdata = mem_rdata passthrough.
//  Latency: request in IDLE at cycle N -> mem strobe in cycle N+1 -> resp in the same cycle as mem_resp.
//   Minimum 2 cycles.
//  The requester deasserts in the cycle after resp. IDLE always lasts >= 1 cycle between transactions,
//   so a stale request is never re-granted.
//  A request arriving while the other port is served stays pending and is granted from the next IDLE.
//   Back-to-back contention therefore alternates I, D, I, D.
//  d_read & d_write both high: treated as a write.
//  Requester dropping its request mid-service: the transaction still completes (memory cannot abort),
//   and the resp pulse is still issued.
//  mem_resp in IDLE: ignored; no resp pulse.
//  Counters:
//   - Saturate at all-ones.
//   - perf_conflict increments when state is SERVE_I and d_read|d_write, or state is SERVE_D and i_read.
//   - perf_clear has priority over any increment in the same cycle.
//  Reset mid-transaction: strobes drop immediately and the FSM returns to IDLE. No resp is issued for
//   the aborted transaction.
// TESTING
//  1. Reset, then i_read=1 @0x100; memory resps after 3 cycles -> mem_read high cycles 1-3, i_resp
//     pulses in cycle 3 with i_rdata=mem_rdata, perf_i_grant=1.
//  2. i_read and d_read both high in the same cycle after reset -> D served first, then I;
//     perf_conflict = D service length in cycles.
//  3. Both held continuously for 4 transactions -> grant order D, I, D, I; every mem_address matches
//     the requester.
//  4. d_write @0x40, wdata=0xA5.., byte_en=0x0F; d_address changed mid-service -> mem_address stays
//     0x40; mem_write asserted, mem_read never.
//  5. rst_n pulsed low during SERVE_D -> mem_write falls asynchronously; no d_resp; next request
//     granted normally.
//  6. Force perf_d_grant to all-ones and grant once more -> holds all-ones; assert perf_clear with a
//     grant in the same cycle -> 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the I/D requesters, the arbiter and the shared memory.
// slave  : the arbiter's view (takes requests and memory replies, drives responses and strobes)
// master : the environment's view (requesters plus memory)
interface mem_port_arbiter_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_byte_en;
  logic [DATA_W-1:0] d_rdata;
  logic              d_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_byte_en;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_read, i_address,
    output i_rdata, i_resp,
    input  d_read, d_write, d_address, d_wdata, d_byte_en,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_en,
    input  mem_rdata, mem_resp
  );

  modport master (
    output i_read, i_address,
    input  i_rdata, i_resp,
    output d_read, d_write, d_address, d_wdata, d_byte_en,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_en,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and data (D).
// One transaction at a time, round-robin on contention, saturating perf counters.
//
// state   | meaning
// IDLE    | no transaction; arbitrate pending requests on the next edge
// SERVE_I | I transaction on the memory port, waiting for mem_resp
// SERVE_D | D transaction on the memory port, waiting for mem_resp
module mem_port_arbiter #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 32,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus,
  input  logic              perf_clear,
  output logic [PERF_W-1:0] perf_i_grant,
  output logic [PERF_W-1:0] perf_d_grant,
  output logic [PERF_W-1:0] perf_conflict
);
  localparam int BE_W = DATA_W / 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  logic [1:0]        state;
  logic              last_grant_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic              write_q;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;
  logic conflict_hit;

  // Arbitration: a lone request wins; on a tie the port not granted last time wins.
  always_comb begin
    i_req        = bus.i_read;
    d_req        = bus.d_read | bus.d_write;
    grant_d      = (state == IDLE) & d_req & (~i_req | ~last_grant_d);
    grant_i      = (state == IDLE) & i_req & ~grant_d;
    conflict_hit = ((state == SERVE_I) & d_req) | ((state == SERVE_D) & i_req);
  end

  // State sequencing; a serve state is left only on the memory's done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d)      state <= SERVE_D;
          else if (grant_i) state <= SERVE_I;
        end
        SERVE_I, SERVE_D: begin
          if (bus.mem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture the granted request so the memory sees stable values even if the requester changes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_d <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      write_q      <= 1'b0;
    end else if (grant_d) begin
      last_grant_d <= 1'b1;
      addr_q       <= bus.d_address;
      wdata_q      <= bus.d_wdata;
      be_q         <= bus.d_byte_en;
      write_q      <= bus.d_write;
    end else if (grant_i) begin
      last_grant_d <= 1'b0;
      addr_q       <= bus.i_address;
      write_q      <= 1'b0;
    end
  end

  // Memory-side outputs depend only on state and latched values, never on live requests.
  always_comb begin
    bus.mem_read    = (state == SERVE_I) | ((state == SERVE_D) & ~write_q);
    bus.mem_write   = (state == SERVE_D) & write_q;
    bus.mem_address = addr_q;
    bus.mem_wdata   = wdata_q;
    bus.mem_byte_en = be_q;
    bus.i_resp      = bus.mem_resp & (state == SERVE_I);
    bus.d_resp      = bus.mem_resp & (state == SERVE_D);
    bus.i_rdata     = bus.mem_rdata;
    bus.d_rdata     = bus.mem_rdata;
  end

  // I grant counter; clear beats increment, holds at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           perf_i_grant <= '0;
    else if (perf_clear)                  perf_i_grant <= '0;
    else if (grant_i && !(&perf_i_grant)) perf_i_grant <= perf_i_grant + 1'b1;
  end

  // D grant counter; clear beats increment, holds at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           perf_d_grant <= '0;
    else if (perf_clear)                  perf_d_grant <= '0;
    else if (grant_d && !(&perf_d_grant)) perf_d_grant <= perf_d_grant + 1'b1;
  end

  // Counts cycles one port waits while the other owns the memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 perf_conflict <= '0;
    else if (perf_clear)                        perf_conflict <= '0;
    else if (conflict_hit && !(&perf_conflict)) perf_conflict <= perf_conflict + 1'b1;
  end
endmodule
